// File: rtl/cla_serial_subtractor_pkg.sv
// rtl/cla_serial_subtractor_pkg.sv - shared types and constants for the serial borrow-lookahead subtractor
package cla_sub_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam int SLICE_W = 4;

  function automatic int nibbles(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/cla_serial_subtractor_if.sv
// rtl/cla_serial_subtractor_if.sv - operand/result handshake bundle; lt/eq present when SUB_COMPARE_EN is defined
interface cla_serial_subtractor_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             ovf;
`ifdef SUB_COMPARE_EN
  logic             lt;
  logic             eq;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, d, bout, ovf, lt, eq
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, d, bout, ovf, lt, eq
  );
`else
  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, d, bout, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, d, bout, ovf
  );
`endif

endinterface

// File: rtl/cla_serial_subtractor_bla4_sub.sv
// rtl/cla_serial_subtractor_bla4_sub.sv - combinational 4-bit borrow-lookahead subtract slice
module bla4_sub
  import cla_sub_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               bin,
  output logic [SLICE_W-1:0] d,
  output logic               bout
);

  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W-1:0] br;

  // Generate when a=0,b=1; propagate an incoming borrow when a==b.
  assign g = ~a & b;
  assign p = ~(a ^ b);

  assign br[0] = bin;
  assign br[1] = g[0] | (p[0] & bin);
  assign br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
  assign br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bin);
  assign bout  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & bin);

  assign d = a ^ b ^ br;

endmodule

// File: rtl/cla_serial_subtractor.sv
// rtl/cla_serial_subtractor.sv - multi-cycle subtractor, one nibble per clock; SUB_COMPARE_EN adds lt/eq outputs
module cla_serial_subtractor
  import cla_sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic                    clk,
  input logic                    rst,
  cla_serial_subtractor_if.slave bus
);

  localparam int NIBBLES = nibbles(WIDTH);
  localparam int IW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  state_t             state;
  state_t             state_nxt;
  logic [IW-1:0]      idx;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   d_r;
  logic               brw;
  logic               bout_r;
  logic               ovf_r;
  logic [SLICE_W-1:0] a_s;
  logic [SLICE_W-1:0] b_s;
  logic [SLICE_W-1:0] s_d;
  logic               s_bout;

  assign a_s = a_r[int'(idx)*SLICE_W +: SLICE_W];
  assign b_s = b_r[int'(idx)*SLICE_W +: SLICE_W];

  bla4_sub u_slice (
    .a    (a_s),
    .b    (b_s),
    .bin  (brw),
    .d    (s_d),
    .bout (s_bout)
  );

`ifdef SUB_COMPARE_EN
  logic               cbrw;
  logic               cnz;
  logic               lt_r;
  logic               eq_r;
  logic [SLICE_W-1:0] c_d;
  logic               c_bout;

  // Borrow-free chain: its final borrow is a<b, and its difference is zero only when a==b.
  bla4_sub u_cmp (
    .a    (a_s),
    .b    (b_s),
    .bin  (cbrw),
    .d    (c_d),
    .bout (c_bout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cbrw <= 1'b0;
      cnz  <= 1'b0;
      lt_r <= 1'b0;
      eq_r <= 1'b0;
    end else if (state == S_IDLE && bus.in_valid) begin
      cbrw <= 1'b0;
      cnz  <= 1'b0;
      lt_r <= 1'b0;
      eq_r <= 1'b0;
    end else if (state == S_RUN) begin
      cbrw <= c_bout;
      cnz  <= cnz | (|c_d);
      if (idx == LAST) begin
        lt_r <= c_bout;
        eq_r <= ~(cnz | (|c_d));
      end
    end
  end

  assign bus.lt = lt_r;
  assign bus.eq = eq_r;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.in_valid) state_nxt = S_RUN;
      S_RUN:   if (idx == LAST) state_nxt = S_DONE;
      S_DONE:  if (bus.out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      d_r    <= '0;
      brw    <= 1'b0;
      bout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_r <= bus.a;
            b_r <= bus.b;
            brw <= bus.bin;
            idx <= '0;
            d_r <= '0;
          end
        end
        S_RUN: begin
          d_r[int'(idx)*SLICE_W +: SLICE_W] <= s_d;
          brw <= s_bout;
          if (idx == LAST) begin
            bout_r <= s_bout;
            ovf_r  <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (s_d[SLICE_W-1] != a_r[WIDTH-1]);
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.d         = d_r;
  assign bus.bout      = bout_r;
  assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_cla_serial_subtractor.sv
// tb/tb_cla_serial_subtractor.sv - randomized self-checking bench against an arithmetic reference model
module tb_cla_serial_subtractor;

  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cla_serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  cla_serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Entered and left at #1 after a rising edge with the block idle.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bin, input int hold);
    int          cyc;
    int          r;
    logic [15:0] ed;
    logic        eb;
    logic        eo;
    ed = a - b - 16'(bin);
    eb = (int'(a) < int'(b) + int'(bin));
    r  = int'($signed(a)) - int'($signed(b)) - int'(bin);
    eo = (r > 32767) || (r < -32768);

    check("in_ready_idle", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.bin      = bin;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a        = 16'($urandom);
    bus.b        = 16'($urandom);
    bus.bin      = 1'($urandom);

    cyc = 0;
    while (!bus.out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", cyc, 4);
    check("d", bus.d, ed);
    check("bout", bus.bout, eb);
    check("ovf", bus.ovf, eo);
`ifdef SUB_COMPARE_EN
    check("lt", bus.lt, a < b);
    check("eq", bus.eq, a == b);
`endif

    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'($urandom);
      @(posedge clk); #1;
      check("hold_valid", bus.out_valid, 1);
      check("hold_d", bus.d, ed);
      check("hold_bout", bus.bout, eb);
      check("hold_in_ready", bus.in_ready, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("out_valid_clear", bus.out_valid, 0);
    check("in_ready_back", bus.in_ready, 1);
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_d", bus.d, 0);
    check("rst_bout", bus.bout, 0);
    check("rst_ovf", bus.ovf, 0);
`ifdef SUB_COMPARE_EN
    check("rst_lt", bus.lt, 0);
    check("rst_eq", bus.eq, 0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(16'h1234, 16'h0234, 1'b0, 0);
    run_op(16'h0000, 16'h0001, 1'b0, 0);
    run_op(16'h8000, 16'h0001, 1'b0, 0);
    run_op(16'h1000, 16'h0000, 1'b1, 0);
    run_op(16'hFFFF, 16'h7FFF, 1'b0, 3);
    run_op(16'h0005, 16'h0007, 1'b0, 0);
    run_op(16'hABCD, 16'hABCD, 1'b0, 1);

    bus.in_valid = 1'b1;
    bus.a        = 16'h4321;
    bus.b        = 16'h1234;
    bus.bin      = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_d", bus.d, 0);
    check("abort_in_ready", bus.in_ready, 1);
    run_op(16'h4321, 16'h1234, 1'b1, 0);

    for (int n = 0; n < 40; n++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
